// File: rtl/mpu_view_pkg.sv
// Shared constants and elaboration-time helpers for the MPU-6050 LED viewer.
//   BYTE_W            : width of one displayed byte
//   ERR_BIT / ACK_BIT : positions of the sticky-error and ack LEDs in the LED bus
//   clog2             : ceiling log2, clog2(1) = 0
//   calc_nsel         : number of selectable display slots
//   calc_idx_w        : width of the selection index (never below 1)
package mpu_view_pkg;

    localparam int BYTE_W  = 8;
    localparam int ERR_BIT = 9;
    localparam int ACK_BIT = 8;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // The ack counter, when present, occupies one extra slot after the data bytes.
    function automatic int calc_nsel(input int nbytes, input bit ackcnt_en);
        return ackcnt_en ? nbytes + 1 : nbytes;
    endfunction

    function automatic int calc_idx_w(input int nsel);
        return (nsel > 1) ? clog2(nsel) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a consecutive-cycle
// debounce counter.
// Ports:
//   CLK       : system clock
//   RST       : synchronous reset, active-high; returns to the released state
//   I_KEY_n   : raw button, active-low, asynchronous to CLK
//   O_PRESSED : debounced level, 1 while the button is held
//   O_PRESS_P : one-cycle pulse on each released->pressed transition
module key_debounce
    import mpu_view_pkg::*;
#(
    parameter int DB_CNT = 500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic I_KEY_n,
    output logic O_PRESSED,
    output logic O_PRESS_P
);

    localparam int CNT_W = (DB_CNT > 1) ? clog2(DB_CNT) : 1;

    logic             key_meta;
    logic             key_sync;
    logic             raw_pressed;
    logic [CNT_W-1:0] cnt;

    assign raw_pressed = ~key_sync;

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            cnt       <= '0;
            O_PRESSED <= 1'b0;
            O_PRESS_P <= 1'b0;
        end else begin
            key_meta  <= I_KEY_n;
            key_sync  <= key_meta;
            O_PRESS_P <= 1'b0;
            // cnt holds how many consecutive cycles the raw level has disagreed
            // with the debounced level; any agreeing cycle restarts the run.
            if (raw_pressed == O_PRESSED) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CNT - 1)) begin
                cnt       <= '0;
                O_PRESSED <= raw_pressed;
                O_PRESS_P <= raw_pressed;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_led_viewer.sv
// Result viewer between the MPU-6050 I2C controller and the board LEDs.
// Snapshots the receive buffer on each completed transaction, shows one byte
// on the LEDs, steps the byte with a debounced key, and drives a sticky error
// LED and a stretched ack LED.
// Optional build macro: MPU_VIEW_ACKCNT_EN adds a saturating ack-edge counter
// as an extra display slot after the data bytes.
// Ports:
//   CLK, RST    : clock and synchronous active-high reset
//   I_ACK       : controller ack flag, rising edge = completed transaction
//   I_ERR       : controller error flag (level)
//   I_RXD       : controller receive buffer, byte 0 in the LSBs
//   I_KEY_NEXT  : raw next button, active-low, asynchronous
//   I_FREEZE    : 1 keeps the current snapshot
//   I_CLR_ERR   : pulse clearing the sticky error (and the ack counter)
//   O_LEDR      : {err_sticky, ack_stretched, selected byte}
//   O_IDX       : selected display slot
//   O_SNAP_VLD  : 1 once any snapshot has been taken
module mpu_led_viewer
    import mpu_view_pkg::*;
#(
    parameter int FPGA_CLK       = 50_000_000,
    parameter int RXD_SZ         = 24,
    parameter int DB_MS          = 10,
    parameter int ACK_STRETCH_MS = 100,
`ifdef MPU_VIEW_ACKCNT_EN
    localparam bit ACKCNT_EN     = 1'b1,
`else
    localparam bit ACKCNT_EN     = 1'b0,
`endif
    localparam int NBYTES        = RXD_SZ / BYTE_W,
    localparam int NSEL          = calc_nsel(NBYTES, ACKCNT_EN),
    localparam int IDX_W         = calc_idx_w(NSEL)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_ACK,
    input  logic              I_ERR,
    input  logic [RXD_SZ-1:0] I_RXD,
    input  logic              I_KEY_NEXT,
    input  logic              I_FREEZE,
    input  logic              I_CLR_ERR,
    output logic [9:0]        O_LEDR,
    output logic [IDX_W-1:0]  O_IDX,
    output logic              O_SNAP_VLD
);

    localparam int DB_CNT  = FPGA_CLK / 1000 * DB_MS;
    localparam int STR_CNT = FPGA_CLK / 1000 * ACK_STRETCH_MS;
    localparam int STR_W   = (STR_CNT > 0) ? clog2(STR_CNT + 1) : 1;

    logic              ack_q;
    logic              ack_edge;
    logic [RXD_SZ-1:0] snapshot;
    logic              snap_vld;
    logic [STR_W-1:0]  str_cnt;
    logic              err_sticky;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] sel_byte;
    logic [BYTE_W-1:0] led_byte;
    logic              key_pressed;
    logic              key_press_p;
    logic              step;

    assign ack_edge = I_ACK & ~ack_q;

    key_debounce #(
        .DB_CNT (DB_CNT)
    ) u_key (
        .CLK       (CLK),
        .RST       (RST),
        .I_KEY_n   (I_KEY_NEXT),
        .O_PRESSED (key_pressed),
        .O_PRESS_P (key_press_p)
    );

    // The pulse is only ever raised together with the pressed level.
    assign step = key_press_p & key_pressed;

`ifdef MPU_VIEW_ACKCNT_EN
    logic [BYTE_W-1:0] ack_cnt;

    always_ff @(posedge CLK) begin
        if (RST || I_CLR_ERR) begin
            ack_cnt <= '0;
        end else if (ack_edge && (ack_cnt != '1)) begin
            ack_cnt <= ack_cnt + BYTE_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q    <= 1'b0;
            snapshot <= '0;
            snap_vld <= 1'b0;
        end else begin
            ack_q <= I_ACK;
            if (ack_edge && !I_FREEZE) begin
                snapshot <= I_RXD;
                snap_vld <= 1'b1;
            end
        end
    end

    // Down-counter; an ack edge always reloads it, even mid-count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            str_cnt <= '0;
        end else if (ack_edge) begin
            str_cnt <= STR_W'(STR_CNT);
        end else if (str_cnt != '0) begin
            str_cnt <= str_cnt - STR_W'(1);
        end
    end

    // A new error in the clearing cycle must not be lost, so set wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_sticky <= 1'b0;
        end else if (I_ERR) begin
            err_sticky <= 1'b1;
        end else if (I_CLR_ERR) begin
            err_sticky <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx <= '0;
        end else if (step) begin
            idx <= (idx == IDX_W'(NSEL - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_byte = snapshot[k*BYTE_W +: BYTE_W];
            end
        end
`ifdef MPU_VIEW_ACKCNT_EN
        if (idx == IDX_W'(NBYTES)) begin
            sel_byte = ack_cnt;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            led_byte <= '0;
        end else begin
            led_byte <= sel_byte;
        end
    end

    assign O_LEDR[ERR_BIT]      = err_sticky;
    assign O_LEDR[ACK_BIT]      = (str_cnt != '0);
    assign O_LEDR[BYTE_W-1:0]   = led_byte;
    assign O_IDX                = idx;
    assign O_SNAP_VLD           = snap_vld;

endmodule

// File: tb/tb_mpu_led_viewer.sv
// Scoreboard bench for mpu_led_viewer with a fast clock configuration
// (DB_CNT = 1000, STR_CNT = 1000, 3 data bytes).
module tb_mpu_led_viewer;

`ifdef MPU_VIEW_ACKCNT_EN
    localparam int NSEL_TB = 4;
`else
    localparam int NSEL_TB = 3;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_ACK;
    logic        I_ERR;
    logic [23:0] I_RXD;
    logic        I_KEY_NEXT;
    logic        I_FREEZE;
    logic        I_CLR_ERR;
    logic [9:0]  O_LEDR;
    logic [1:0]  O_IDX;
    logic        O_SNAP_VLD;

    mpu_led_viewer #(
        .FPGA_CLK       (1_000_000),
        .RXD_SZ         (24),
        .DB_MS          (1),
        .ACK_STRETCH_MS (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_ACK      (I_ACK),
        .I_ERR      (I_ERR),
        .I_RXD      (I_RXD),
        .I_KEY_NEXT (I_KEY_NEXT),
        .I_FREEZE   (I_FREEZE),
        .I_CLR_ERR  (I_CLR_ERR),
        .O_LEDR     (O_LEDR),
        .O_IDX      (O_IDX),
        .O_SNAP_VLD (O_SNAP_VLD)
    );

    always #5 CLK = ~CLK;

    // Observed vector: {O_SNAP_VLD, O_IDX, O_LEDR}
    typedef struct {
        string       name;
        logic [12:0] mask;
        logic [12:0] val;
    } pt_t;

    typedef struct {
        string      name;
        logic [1:0] idx;
        logic [7:0] byte_v;
    } st_t;

    pt_t  pt_q[$];
    st_t  st_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    logic [1:0] prev_idx = 2'd0;
    st_t  pend;
    bit   pend_v   = 1'b0;

    always @(negedge CLK) begin : monitor
        pt_t p;
        st_t s;
        while (pt_q.size() > 0) begin
            p = pt_q.pop_front();
            n_checks++;
            if (({O_SNAP_VLD, O_IDX, O_LEDR} & p.mask) !== (p.val & p.mask)) begin
                n_errors++;
                $display("FAIL %s: got vld/idx/ledr=%h required %h (mask %h)",
                         p.name, {O_SNAP_VLD, O_IDX, O_LEDR}, p.val, p.mask);
            end
        end
        if (pend_v) begin
            pend_v = 1'b0;
            n_checks++;
            if (O_LEDR[7:0] !== pend.byte_v) begin
                n_errors++;
                $display("FAIL %s_byte: got LED byte %h required %h",
                         pend.name, O_LEDR[7:0], pend.byte_v);
            end
        end
        if (!mon_en) begin
            prev_idx = O_IDX;
        end else if (O_IDX !== prev_idx) begin
            prev_idx = O_IDX;
            n_checks++;
            if (st_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_step: idx became %0d, required no change", O_IDX);
            end else begin
                s = st_q.pop_front();
                if (O_IDX !== s.idx) begin
                    n_errors++;
                    $display("FAIL %s_idx: got idx %0d required %0d", s.name, O_IDX, s.idx);
                end
                pend   = s;
                pend_v = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_pt(input string name, input logic [12:0] mask, input logic [12:0] val);
        pt_t p;
        p.name = name;
        p.mask = mask;
        p.val  = val;
        pt_q.push_back(p);
    endtask

    task automatic push_step(input string name, input logic [1:0] idx, input logic [7:0] b);
        st_t s;
        s.name   = name;
        s.idx    = idx;
        s.byte_v = b;
        st_q.push_back(s);
    endtask

    task automatic press(input int hold);
        I_KEY_NEXT = 1'b0;
        tick(hold);
        I_KEY_NEXT = 1'b1;
        tick(1500);
    endtask

    // Bytes of 24'hA53C81; slot 3 (ack counter build) holds one counted edge.
    function automatic logic [7:0] exp_byte(input int i);
        case (i)
            0:       return 8'h81;
            1:       return 8'h3C;
            2:       return 8'hA5;
            default: return 8'h01;
        endcase
    endfunction

    initial begin
        RST        = 1'b1;
        I_ACK      = 1'b0;
        I_ERR      = 1'b0;
        I_RXD      = 24'hA53C81;
        I_KEY_NEXT = 1'b1;
        I_FREEZE   = 1'b0;
        I_CLR_ERR  = 1'b0;
        tick(3);
        expect_pt("reset_state", 13'h1FFF, 13'h0000);
        RST    = 1'b0;
        mon_en = 1'b1;

        // Snapshot latency and stretch width
        tick(6);
        I_ACK = 1'b1;
        tick(1);
        expect_pt("ack_first_cycle", 13'h1FFF, {1'b1, 2'd0, 10'h100});
        I_ACK = 1'b0;
        tick(1);
        expect_pt("snapshot_byte0", 13'h1FFF, {1'b1, 2'd0, 10'h181});
        tick(998);
        expect_pt("stretch_last", 13'h0100, 13'h0100);
        tick(1);
        expect_pt("stretch_end", 13'h1FFF, {1'b1, 2'd0, 10'h081});

        // Step and wrap
        for (int i = 1; i <= NSEL_TB; i++) begin
            push_step("step_wrap", 2'(i % NSEL_TB), exp_byte(i % NSEL_TB));
            press(1500);
        end
        expect_pt("idx_after_wrap", 13'h0CFF, {1'b0, 2'd0, 10'h081});

        // Bounce, short and exact-length pulses
        for (int i = 0; i < 17; i++) begin
            I_KEY_NEXT = ~I_KEY_NEXT;
            tick(300);
        end
        I_KEY_NEXT = 1'b1;
        tick(1500);
        expect_pt("bounce_no_step", 13'h0CFF, {1'b0, 2'd0, 10'h081});
        press(999);
        expect_pt("pulse_999_no_step", 13'h0CFF, {1'b0, 2'd0, 10'h081});
        push_step("pulse_1000", 2'd1, 8'h3C);
        press(1000);
        expect_pt("pulse_1000_idx", 13'h0CFF, {1'b0, 2'd1, 10'h03C});

        for (int i = 2; i <= NSEL_TB; i++) begin
            push_step("step_to_zero", 2'(i % NSEL_TB), exp_byte(i % NSEL_TB));
            press(1500);
        end

        // Freeze and retrigger
        I_FREEZE = 1'b1;
        I_RXD    = 24'hFFFFFF;
        I_ACK    = 1'b1;
        tick(1);
        expect_pt("freeze_ack_start", 13'h1FFF, {1'b1, 2'd0, 10'h181});
        I_ACK = 1'b0;
        tick(1);
        expect_pt("freeze_keeps_byte", 13'h1FFF, {1'b1, 2'd0, 10'h181});
        tick(498);
        I_ACK = 1'b1;
        tick(1);
        I_ACK = 1'b0;
        tick(500);
        expect_pt("retrigger_holds", 13'h01FF, {1'b0, 2'd0, 10'h181});
        tick(499);
        expect_pt("retrigger_last", 13'h0100, 13'h0100);
        tick(1);
        expect_pt("retrigger_end", 13'h1FFF, {1'b1, 2'd0, 10'h081});
        I_FREEZE = 1'b0;
        I_RXD    = 24'hA53C81;

        // Sticky error
        I_ERR = 1'b1;
        tick(1);
        I_ERR = 1'b0;
        expect_pt("err_set", 13'h0200, 13'h0200);
        tick(5);
        expect_pt("err_holds", 13'h0200, 13'h0200);
        I_ERR     = 1'b1;
        I_CLR_ERR = 1'b1;
        tick(1);
        I_ERR     = 1'b0;
        I_CLR_ERR = 1'b0;
        expect_pt("err_set_wins", 13'h0200, 13'h0200);
        tick(1);
        expect_pt("err_still_set", 13'h0200, 13'h0200);
        I_CLR_ERR = 1'b1;
        tick(1);
        I_CLR_ERR = 1'b0;
        expect_pt("err_cleared", 13'h0200, 13'h0000);

        // Reset in the middle of a stretch and a debounce
        push_step("reset_prep", 2'd1, 8'h3C);
        press(1500);
        push_step("reset_prep", 2'd2, 8'hA5);
        press(1500);
        I_ERR = 1'b1;
        tick(1);
        I_ERR = 1'b0;
        I_ACK = 1'b1;
        tick(1);
        I_ACK = 1'b0;
        expect_pt("pre_reset_state", 13'h1FFF, {1'b1, 2'd2, 10'h3A5});
        tick(299);
        I_KEY_NEXT = 1'b0;
        tick(201);
        push_step("reset_idx", 2'd0, 8'h00);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        expect_pt("reset_mid_op", 13'h1FFF, 13'h0000);
        tick(985);
        expect_pt("no_early_press", 13'h1FFF, 13'h0000);
        push_step("held_after_reset", 2'd1, 8'h00);
        tick(30);
        expect_pt("press_after_reset", 13'h1FFF, {1'b0, 2'd1, 10'h000});
        I_KEY_NEXT = 1'b1;
        tick(1500);

        n_checks++;
        if (st_q.size() != 0) begin
            n_errors++;
            $display("FAIL steps_pending: %0d expected steps never seen, required 0", st_q.size());
        end
        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
